// File: rtl/image_crop_stream.sv
// Streaming crop stage: forwards the OUT_ROWS x OUT_COLS window at (crop_y1, crop_x1)
// out of a raster-order IN_ROWS x IN_COLS frame, under ap_start/ap_done block control.
module image_crop_stream #(
    parameter int FP_TOTAL = 16,
    parameter int IN_ROWS  = 100,
    parameter int IN_COLS  = 160,
    parameter int OUT_ROWS = 48,
    parameter int OUT_COLS = 48
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst_n,
    input  logic                       ap_start,
    output logic                       ap_done,
    output logic                       ap_idle,
    output logic                       ap_ready,
    input  logic [$clog2(IN_ROWS)-1:0] crop_y1,
    input  logic [$clog2(IN_COLS)-1:0] crop_x1,
    output logic                       crop_err,
    input  logic [FP_TOTAL-1:0]        img_in_TDATA,
    input  logic                       img_in_TVALID,
    output logic                       img_in_TREADY,
    output logic [FP_TOTAL-1:0]        crop_out_TDATA,
    output logic                       crop_out_TVALID,
    input  logic                       crop_out_TREADY
);

    localparam int RW = $clog2(IN_ROWS);
    localparam int CW = $clog2(IN_COLS);

    // Window bounds are compared one bit wider so y1+OUT_ROWS cannot wrap.
    localparam logic [RW:0]   ROWS_X     = (RW+1)'(IN_ROWS);
    localparam logic [RW:0]   WIN_ROWS_X = (RW+1)'(OUT_ROWS);
    localparam logic [CW:0]   COLS_X     = (CW+1)'(IN_COLS);
    localparam logic [CW:0]   WIN_COLS_X = (CW+1)'(OUT_COLS);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IN_ROWS - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(IN_COLS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [RW-1:0] y1;
    logic [RW-1:0] row;
    logic [CW-1:0] x1;
    logic [CW-1:0] col;
    logic [RW:0]   y_lo;
    logic [RW:0]   y_hi;
    logic [CW:0]   x_lo;
    logic [CW:0]   x_hi;
    logic          start_ok;
    logic          in_ready;
    logic          in_fire;
    logic          out_fire;
    logic          out_free;
    logic          last_pix;
    logic          in_window;

    assign start_ok = (({1'b0, crop_y1} + WIN_ROWS_X) <= ROWS_X) &&
                      (({1'b0, crop_x1} + WIN_COLS_X) <= COLS_X);

    assign y_lo      = {1'b0, y1};
    assign y_hi      = y_lo + WIN_ROWS_X;
    assign x_lo      = {1'b0, x1};
    assign x_hi      = x_lo + WIN_COLS_X;
    assign in_window = ({1'b0, row} >= y_lo) && ({1'b0, row} < y_hi) &&
                       ({1'b0, col} >= x_lo) && ({1'b0, col} < x_hi);
    assign last_pix  = (row == ROW_LAST) && (col == COL_LAST);

    // The single output register can take a new pixel when empty or draining this cycle.
    assign out_free = ~crop_out_TVALID | crop_out_TREADY;
    assign out_fire = crop_out_TVALID & crop_out_TREADY;
    assign in_ready = (state == S_RUN) && out_free;
    assign in_fire  = img_in_TVALID & in_ready;

    assign img_in_TREADY = in_ready;
    assign ap_idle       = (state == S_IDLE);
    assign ap_done       = (state == S_DONE);
    assign ap_ready      = in_fire & last_pix;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (ap_start) begin
                    state_next = start_ok ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (in_fire && last_pix) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_free) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            y1       <= '0;
            x1       <= '0;
            row      <= '0;
            col      <= '0;
            crop_err <= 1'b0;
        end else if ((state == S_IDLE) && ap_start) begin
            y1       <= crop_y1;
            x1       <= crop_x1;
            row      <= '0;
            col      <= '0;
            crop_err <= ~start_ok;
        end else if (in_fire) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Out-of-window pixels leave the register alone unless it drains in the same cycle.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            crop_out_TDATA  <= '0;
            crop_out_TVALID <= 1'b0;
        end else if (in_fire && in_window) begin
            crop_out_TDATA  <= img_in_TDATA;
            crop_out_TVALID <= 1'b1;
        end else if (out_fire) begin
            crop_out_TVALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_image_crop_stream.sv
// Scoreboard bench for image_crop_stream on a reduced 25x40 frame with a 12x12 window;
// expected pixels are queued at each input handshake and popped at each output beat.
module tb_image_crop_stream;

    localparam int FP_TOTAL = 16;
    localparam int IN_ROWS  = 25;
    localparam int IN_COLS  = 40;
    localparam int OUT_ROWS = 12;
    localparam int OUT_COLS = 12;
    localparam int RW       = $clog2(IN_ROWS);
    localparam int CW       = $clog2(IN_COLS);
    localparam int TOTAL    = IN_ROWS * IN_COLS;
    localparam int WIN      = OUT_ROWS * OUT_COLS;

    logic                ap_clk;
    logic                ap_rst_n;
    logic                ap_start;
    logic                ap_done;
    logic                ap_idle;
    logic                ap_ready;
    logic [RW-1:0]       crop_y1;
    logic [CW-1:0]       crop_x1;
    logic                crop_err;
    logic [FP_TOTAL-1:0] img_in_TDATA;
    logic                img_in_TVALID;
    logic                img_in_TREADY;
    logic [FP_TOTAL-1:0] crop_out_TDATA;
    logic                crop_out_TVALID;
    logic                crop_out_TREADY;

    image_crop_stream #(
        .FP_TOTAL (FP_TOTAL),
        .IN_ROWS  (IN_ROWS),
        .IN_COLS  (IN_COLS),
        .OUT_ROWS (OUT_ROWS),
        .OUT_COLS (OUT_COLS)
    ) dut (
        .ap_clk          (ap_clk),
        .ap_rst_n        (ap_rst_n),
        .ap_start        (ap_start),
        .ap_done         (ap_done),
        .ap_idle         (ap_idle),
        .ap_ready        (ap_ready),
        .crop_y1         (crop_y1),
        .crop_x1         (crop_x1),
        .crop_err        (crop_err),
        .img_in_TDATA    (img_in_TDATA),
        .img_in_TVALID   (img_in_TVALID),
        .img_in_TREADY   (img_in_TREADY),
        .crop_out_TDATA  (crop_out_TDATA),
        .crop_out_TVALID (crop_out_TVALID),
        .crop_out_TREADY (crop_out_TREADY)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int errors = 0;
    int q[$];

    int m_y1, m_x1, m_row, m_col;
    int pix_sent, out_cnt, first_out, last_out, ready_cnt, done_cnt;
    int cyc, start_cyc, valid_pct, ready_pct, stall_left, prev_data, load_val;
    bit m_ok, active, pend, start_req, hold_start, prev_hold, prev_load;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic frame_done_checks();
        check_eq("done_crop_err", 32'(crop_err), m_ok ? 0 : 1);
        check_eq("out_count", out_cnt, m_ok ? WIN : 0);
        check_eq("ready_count", ready_cnt, m_ok ? 1 : 0);
        check_eq("in_count", pix_sent, m_ok ? TOTAL : 0);
        check_eq("queue_empty", q.size(), 0);
        if (m_ok) begin
            check_eq("first_pixel", first_out, m_y1 * IN_COLS + m_x1);
            check_eq("last_pixel", last_out,
                     (m_y1 + OUT_ROWS - 1) * IN_COLS + m_x1 + OUT_COLS - 1);
        end else begin
            check_eq("err_done_latency", 32'((cyc - start_cyc) <= 2), 1);
        end
    endtask

    task automatic applyStimulus();
        ap_start = start_req;
        if (!pend && active && pix_sent < TOTAL && $urandom_range(99) < valid_pct)
            pend = 1'b1;
        img_in_TVALID = pend;
        img_in_TDATA  = FP_TOTAL'(m_row * IN_COLS + m_col);
        if (stall_left > 0) begin
            crop_out_TREADY = 1'b0;
            stall_left--;
        end else begin
            crop_out_TREADY = ($urandom_range(99) < ready_pct);
        end
    endtask

    task automatic checkOutput();
        bit fire_in;
        bit fire_out;
        int value;
        if (prev_hold) begin
            check_eq("hold_valid", 32'(crop_out_TVALID), 1);
            check_eq("hold_data", 32'(crop_out_TDATA), prev_data);
        end
        if (prev_load) begin
            check_eq("latency_valid", 32'(crop_out_TVALID), 1);
            check_eq("latency_data", 32'(crop_out_TDATA), load_val);
        end
        if (crop_out_TVALID && !crop_out_TREADY)
            check_eq("in_ready_blocked", 32'(img_in_TREADY), 0);
        fire_in   = img_in_TVALID && img_in_TREADY;
        fire_out  = crop_out_TVALID && crop_out_TREADY;
        prev_hold = crop_out_TVALID && !crop_out_TREADY;
        prev_data = int'(crop_out_TDATA);
        prev_load = 1'b0;
        if (fire_out) begin
            check_eq("beat_expected", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                value = q.pop_front();
                check_eq("out_data", 32'(crop_out_TDATA), value);
            end
            if (out_cnt == 0) first_out = int'(crop_out_TDATA);
            last_out = int'(crop_out_TDATA);
            out_cnt++;
        end
        if (ap_ready) ready_cnt++;
        if (fire_in) begin
            value = m_row * IN_COLS + m_col;
            if (m_row >= m_y1 && m_row < m_y1 + OUT_ROWS &&
                m_col >= m_x1 && m_col < m_x1 + OUT_COLS) begin
                q.push_back(value);
                prev_load = 1'b1;
                load_val  = value;
            end
            if (m_row == IN_ROWS - 1 && m_col == IN_COLS - 1)
                check_eq("ap_ready_last", 32'(ap_ready), 1);
            if (m_col == IN_COLS - 1) begin
                m_col = 0;
                m_row++;
            end else begin
                m_col++;
            end
            pix_sent++;
            pend = 1'b0;
        end
        if (ap_done) begin
            done_cnt++;
            frame_done_checks();
            active = 1'b0;
            pend   = 1'b0;
        end
        if (ap_idle && ap_start) begin
            m_y1      = int'(crop_y1);
            m_x1      = int'(crop_x1);
            m_ok      = (m_y1 + OUT_ROWS <= IN_ROWS) && (m_x1 + OUT_COLS <= IN_COLS);
            m_row     = 0;
            m_col     = 0;
            pix_sent  = 0;
            out_cnt   = 0;
            ready_cnt = 0;
            active    = 1'b1;
            start_cyc = cyc;
            if (!hold_start) start_req = 1'b0;
        end
        cyc++;
    endtask

    task automatic cycle_step();
        @(negedge ap_clk);
        applyStimulus();
        #1;
        checkOutput();
    endtask

    task automatic run_frames(input int nf, input int y1, input int x1, input int vpct,
                              input int rpct, input int stall, input bit hold, input int abort_px);
        int target;
        int budget;
        crop_y1    = RW'(y1);
        crop_x1    = CW'(x1);
        valid_pct  = vpct;
        ready_pct  = rpct;
        stall_left = stall;
        hold_start = hold;
        start_req  = 1'b1;
        target     = done_cnt + nf;
        budget     = nf * (TOTAL * 20 + 200) + stall;
        for (int c = 0; c < budget; c++) begin
            cycle_step();
            if (done_cnt >= target) break;
            if (abort_px > 0 && pix_sent >= abort_px) break;
        end
        start_req = 1'b0;
        ap_start  = 1'b0;
        if (abort_px == 0) check_eq("frames_done", done_cnt, target);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_idle"}, 32'(ap_idle), 1);
        check_eq({tag, "_done"}, 32'(ap_done), 0);
        check_eq({tag, "_ready"}, 32'(ap_ready), 0);
        check_eq({tag, "_err"}, 32'(crop_err), 0);
        check_eq({tag, "_tvalid"}, 32'(crop_out_TVALID), 0);
        check_eq({tag, "_tdata"}, 32'(crop_out_TDATA), 0);
        check_eq({tag, "_in_ready"}, 32'(img_in_TREADY), 0);
    endtask

    task automatic do_reset();
        @(negedge ap_clk);
        ap_rst_n        = 1'b0;
        start_req       = 1'b0;
        ap_start        = 1'b0;
        img_in_TVALID   = 1'b0;
        crop_out_TREADY = 1'b0;
        pend            = 1'b0;
        active          = 1'b0;
        prev_hold       = 1'b0;
        prev_load       = 1'b0;
        #1;
        check_reset_values("mid_reset");
        q.delete();
        repeat (3) @(negedge ap_clk);
        ap_rst_n = 1'b1;
    endtask

    initial begin
        int done_before;
        ap_rst_n        = 1'b0;
        ap_start        = 1'b0;
        crop_y1         = '0;
        crop_x1         = '0;
        img_in_TDATA    = '0;
        img_in_TVALID   = 1'b0;
        crop_out_TREADY = 1'b0;
        #1;
        check_reset_values("reset");
        repeat (3) @(negedge ap_clk);
        ap_rst_n = 1'b1;

        $display("[TB] full-rate frame at (10,10)");
        run_frames(1, 10, 10, 100, 100, 0, 1'b0, 0);

        $display("[TB] random backpressure frame at (10,10)");
        run_frames(1, 10, 10, 50, 50, 0, 1'b0, 0);

        $display("[TB] invalid window");
        run_frames(1, IN_ROWS - OUT_ROWS + 1, 0, 100, 100, 0, 1'b0, 0);
        cycle_step();
        check_eq("err_held", 32'(crop_err), 1);
        check_eq("err_idle", 32'(ap_idle), 1);

        $display("[TB] corner windows");
        run_frames(1, 0, 0, 100, 100, 0, 1'b0, 0);
        run_frames(1, IN_ROWS - OUT_ROWS, IN_COLS - OUT_COLS, 100, 100, 0, 1'b0, 0);

        $display("[TB] reset mid-frame");
        done_before = done_cnt;
        run_frames(1, 10, 10, 100, 100, 0, 1'b0, TOTAL / 2);
        do_reset();
        cycle_step();
        check_eq("post_reset_idle", 32'(ap_idle), 1);
        check_eq("post_reset_tvalid", 32'(crop_out_TVALID), 0);
        check_eq("no_done_on_abort", done_cnt, done_before);
        run_frames(1, 10, 10, 100, 100, 0, 1'b0, 0);

        $display("[TB] back-to-back frames with held start and output stall");
        done_before = done_cnt;
        run_frames(2, 10, 10, 100, 100, 3000, 1'b1, 0);
        check_eq("b2b_done_count", done_cnt - done_before, 2);
        repeat (3) cycle_step();
        check_eq("b2b_idle_after", 32'(ap_idle), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
